// File: rtl/ssp_rx_deserializer.sv
// SSP receive deserializer: rebuilds LSB-first framed words and buffers them in a FWFT FIFO.
// Optional build macro SSP_RX_ERRCNT_EN adds a saturating err_count output.
module ssp_rx_deserializer #(
  parameter int WORD_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int AW         = 2
) (
  input  logic                 ck_1356meg,
  input  logic                 rst,
  input  logic                 ssp_frame,
  input  logic                 ssp_din,
  output logic [WORD_BITS-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 frame_err,
  output logic                 overflow,
`ifdef SSP_RX_ERRCNT_EN
  output logic [7:0]           err_count,
`endif
  input  logic                 clr_ovf
);

  // Handshake: a word moves to the consumer on every posedge where
  // out_valid and out_ready are both high; out_data is held stable otherwise.

  localparam int CW = (WORD_BITS > 2) ? $clog2(WORD_BITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(WORD_BITS - 1);

  typedef enum logic {
    HUNT  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [WORD_BITS-2:0]   shreg;

  logic                   push;
  logic [WORD_BITS-1:0]   push_word;

  logic [WORD_BITS-1:0]   mem [FIFO_DEPTH];
  logic [AW:0]            wr_ptr;
  logic [AW:0]            rd_ptr;
  logic                   full;
  logic                   empty;
  logic                   pop;
  logic                   do_push;
  logic                   drop;

  // The last bit is taken straight from the pin so the word lands in the
  // FIFO on the same edge that samples it.
  always_comb begin
    push      = 1'b0;
    push_word = {ssp_din, shreg};
    if (state == SHIFT && !ssp_frame && cnt == LAST)
      push = 1'b1;
  end

  always_ff @(posedge ck_1356meg) begin
    if (rst) begin
      state     <= HUNT;
      cnt       <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        HUNT: begin
          if (ssp_frame) begin
            shreg[0] <= ssp_din;
            cnt      <= CW'(1);
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (ssp_frame) begin
            // Early frame: drop the partial word and restart on this bit 0.
            frame_err <= 1'b1;
            shreg[0]  <= ssp_din;
            cnt       <= CW'(1);
          end else if (cnt == LAST) begin
            cnt   <= '0;
            state <= HUNT;
          end else begin
            for (int i = 0; i < WORD_BITS - 1; i++)
              if (cnt == CW'(i)) shreg[i] <= ssp_din;
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= HUNT;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = out_ready && !empty;
  assign do_push = push && (!full || pop);
  assign drop    = push && full && !pop;

  assign out_valid = !empty;
  // Gated so the output reads zero while the FIFO holds nothing.
  assign out_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge ck_1356meg) begin
    if (do_push)
      mem[wr_ptr[AW-1:0]] <= push_word;
  end

  always_ff @(posedge ck_1356meg) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (drop)
        overflow <= 1'b1;
      else if (clr_ovf)
        overflow <= 1'b0;
    end
  end

`ifdef SSP_RX_ERRCNT_EN
  logic err_event;
  assign err_event = frame_err || drop;

  always_ff @(posedge ck_1356meg) begin
    if (rst)
      err_count <= '0;
    else if (clr_ovf)
      err_count <= err_event ? 8'd1 : 8'd0;
    else if (err_event && err_count != 8'hFF)
      err_count <= err_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_ssp_rx_deserializer.sv
// Directed bench for ssp_rx_deserializer: stream table plus multi-cycle corner sequences.
module tb_ssp_rx_deserializer;

  logic       clk;
  logic       rst;
  logic       ssp_frame;
  logic       ssp_din;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       frame_err;
  logic       overflow;
  logic       clr_ovf;
`ifdef SSP_RX_ERRCNT_EN
  logic [7:0] err_count;
`endif

  ssp_rx_deserializer #(.WORD_BITS(8), .FIFO_DEPTH(4), .AW(2)) dut (
    .ck_1356meg (clk),
    .rst        (rst),
    .ssp_frame  (ssp_frame),
    .ssp_din    (ssp_din),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .frame_err  (frame_err),
    .overflow   (overflow),
`ifdef SSP_RX_ERRCNT_EN
    .err_count  (err_count),
`endif
    .clr_ovf    (clr_ovf)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests;
  int fails;
  int ferr_cycles;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: one full frame, LSB first
  task automatic send_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) begin
      ssp_frame = (i == 0);
      ssp_din   = w[i];
      tick();
    end
    ssp_frame = 1'b0;
    ssp_din   = 1'b0;
  endtask

  // scoreboard: every accepted word must match the head of exp_q
  always @(negedge clk) begin
    if (!rst && frame_err) ferr_cycles++;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got %0h expected none at %0t", out_data, $time);
      end else begin
        check("sb_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  typedef struct {
    logic [7:0] stream;   // bits in transmission order, first-sent at MSB
    logic [7:0] exp_word;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int ferr_base;
    tests = 0;
    fails = 0;
    ferr_cycles = 0;
    vecs[0] = '{8'b10100101, 8'hA5};
    vecs[1] = '{8'b10000000, 8'h01};
    vecs[2] = '{8'b11000000, 8'h03};
    vecs[3] = '{8'b00001111, 8'hF0};
    vecs[4] = '{8'b11100010, 8'h47};
    vecs[5] = '{8'b00000001, 8'h80};

    rst = 1'b1; ssp_frame = 1'b0; ssp_din = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
    tick(); tick();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", {24'd0, out_data}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
`ifdef SSP_RX_ERRCNT_EN
    check("rst_err_count", {24'd0, err_count}, 32'd0);
`endif
    rst = 1'b0;
    tick();

    // T1 and friends: single frames from the table, consumer always ready
    out_ready = 1'b1;
    foreach (vecs[k]) begin
      exp_q.push_back(vecs[k].exp_word);
      for (int i = 0; i < 8; i++) begin
        ssp_frame = (i == 0);
        ssp_din   = vecs[k].stream[7-i];
        if (i == 7) check("vec_no_early_valid", {31'd0, out_valid}, 32'd0);
        tick();
      end
      ssp_frame = 1'b0; ssp_din = 1'b0;
      check("vec_valid", {31'd0, out_valid}, 32'd1);
      check("vec_data", {24'd0, out_data}, {24'd0, vecs[k].exp_word});
      tick();
      check("vec_valid_after", {31'd0, out_valid}, 32'd0);
    end

    // T2: back-to-back frames, then stray data without a frame
    ferr_base = ferr_cycles;
    exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'h3C);
    send_word(8'h00);
    send_word(8'hFF);
    send_word(8'h3C);
    tick();
    check("b2b_drained", exp_q.size(), 32'd0);
    for (int i = 0; i < 10; i++) begin
      ssp_din = i[0];
      tick();
    end
    ssp_din = 1'b0;
    check("noframe_valid", {31'd0, out_valid}, 32'd0);
    check("b2b_no_ferr", ferr_cycles - ferr_base, 32'd0);

    // T3: early frame after 3 bits
    ferr_base = ferr_cycles;
    for (int i = 0; i < 3; i++) begin
      ssp_frame = (i == 0);
      ssp_din   = 1'b1;
      tick();
    end
    exp_q.push_back(8'h5A);
    ssp_frame = 1'b1; ssp_din = 1'b0;
    tick();
    check("early_ferr_pulse", {31'd0, frame_err}, 32'd1);
    for (int i = 1; i < 8; i++) begin
      ssp_frame = 1'b0;
      ssp_din   = 8'h5A >> i;
      tick();
    end
    ssp_din = 1'b0;
    tick();
    check("early_ferr_cycles", ferr_cycles - ferr_base, 32'd1);
    check("early_only_5a", exp_q.size(), 32'd0);

    // T4: overflow with consumer stalled
    out_ready = 1'b0;
    for (int w = 1; w <= 4; w++) send_word(w[7:0]);
    check("ovf_not_yet", {31'd0, overflow}, 32'd0);
    send_word(8'h05);
    check("ovf_set", {31'd0, overflow}, 32'd1);
    check("ovf_head", {24'd0, out_data}, 32'h01);
    for (int w = 1; w <= 4; w++) exp_q.push_back(w[7:0]);
    out_ready = 1'b1;
    repeat (5) tick();
    check("ovf_drained_valid", {31'd0, out_valid}, 32'd0);
    check("ovf_drained_q", exp_q.size(), 32'd0);
    check("ovf_sticky", {31'd0, overflow}, 32'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("ovf_cleared", {31'd0, overflow}, 32'd0);

    // T5: push into a full FIFO with a pop on the same edge
    out_ready = 1'b0;
    send_word(8'h11); send_word(8'h22); send_word(8'h33); send_word(8'h44);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    exp_q.push_back(8'h44); exp_q.push_back(8'h55);
    for (int i = 0; i < 8; i++) begin
      ssp_frame = (i == 0);
      ssp_din   = 8'h55 >> i;
      if (i == 7) out_ready = 1'b1;
      tick();
    end
    ssp_frame = 1'b0; ssp_din = 1'b0;
    out_ready = 1'b0;
    check("full_pop_no_ovf", {31'd0, overflow}, 32'd0);
    check("full_pop_head", {24'd0, out_data}, 32'h22);
    out_ready = 1'b1;
    repeat (3) tick();
    check("full_pop_count4", {31'd0, out_valid}, 32'd1);
    tick();
    check("full_pop_empty", {31'd0, out_valid}, 32'd0);
    check("full_pop_q", exp_q.size(), 32'd0);

    // T6: reset in the middle of a word with the FIFO full and overflow set
    out_ready = 1'b0;
    for (int w = 0; w < 5; w++) send_word(8'h90 + w[7:0]);
    check("pre_rst_ovf", {31'd0, overflow}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      ssp_frame = (i == 0);
      ssp_din   = 1'b1;
      tick();
    end
    ssp_frame = 1'b0;
    rst = 1'b1;
    tick();
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_data", {24'd0, out_data}, 32'd0);
    check("midrst_ovf", {31'd0, overflow}, 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    exp_q.push_back(8'hC3);
    send_word(8'hC3);
    check("post_rst_valid", {31'd0, out_valid}, 32'd1);
    check("post_rst_data", {24'd0, out_data}, 32'hC3);
    tick();
    check("post_rst_q", exp_q.size(), 32'd0);

`ifdef SSP_RX_ERRCNT_EN
    rst = 1'b1; tick(); rst = 1'b0;
    check("errcnt_zero", {24'd0, err_count}, 32'd0);
    ssp_frame = 1'b1;
    repeat (302) tick();
    check("errcnt_sat", {24'd0, err_count}, 32'hFF);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("errcnt_clr_inc", {24'd0, err_count}, 32'd1);
    ssp_frame = 1'b0;
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
